// File: rtl/clusterv_mem_bist_initiator_if.sv
// Wishbone classic-cycle initiator bundle with tag signals.
// The master drives request fields; the slave answers with ack/err/data.
interface clusterv_mem_bist_initiator_if #(
  parameter int ADR_WIDTH = 32,
  parameter int DAT_WIDTH = 32
);
  logic [ADR_WIDTH-1:0] i_adr;
  logic [DAT_WIDTH-1:0] i_dat_w;
  logic [DAT_WIDTH-1:0] i_dat_r;
  logic                 i_cyc;
  logic                 i_err;
  logic [3:0]           i_sel;
  logic                 i_stb;
  logic                 i_ack;
  logic                 i_we;
  logic                 i_tgd_w;
  logic                 i_tga;
  logic                 i_tgc;
  logic                 i_tgd_r;

  modport master (
    output i_adr, i_dat_w, i_cyc, i_sel,
    output i_stb, i_we, i_tgd_w, i_tga, i_tgc,
    input  i_dat_r, i_err, i_ack, i_tgd_r
  );

  modport slave (
    input  i_adr, i_dat_w, i_cyc, i_sel,
    input  i_stb, i_we, i_tgd_w, i_tga, i_tgc,
    output i_dat_r, i_err, i_ack, i_tgd_r
  );
endinterface

// File: rtl/clusterv_mem_bist_initiator.sv
// Memory BIST initiator: fills a region with seed+k, reads it back,
// and reports the first mismatching or erroring word.
module clusterv_mem_bist_initiator #(
  parameter int ADR_WIDTH = 32,
  parameter int DAT_WIDTH = 32,
  parameter int CNT_WIDTH = 12
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADR_WIDTH-1:0] base_adr,
  input  logic [CNT_WIDTH-1:0] nwords,
  input  logic [DAT_WIDTH-1:0] seed,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ADR_WIDTH-1:0] fail_adr,
  output logic [DAT_WIDTH-1:0] fail_data,
  clusterv_mem_bist_initiator_if.master wb
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WGAP,
    RD,
    RGAP,
    FIN
  } state_t;

  state_t state_q, state_n;

  logic [ADR_WIDTH-1:0] base_q, base_n;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_n;
  logic [CNT_WIDTH-1:0] k_q, k_n;
  logic [DAT_WIDTH-1:0] seed_q, seed_n;
  logic                 pass_q, pass_n;
  logic [ADR_WIDTH-1:0] fadr_q, fadr_n;
  logic [DAT_WIDTH-1:0] fdat_q, fdat_n;

  logic [ADR_WIDTH-1:0] cur_adr;
  logic [DAT_WIDTH-1:0] cur_dat;
  logic                 last;
  logic                 act;

  assign cur_adr = base_q + ADR_WIDTH'({k_q, 2'b00});
  assign cur_dat = seed_q + DAT_WIDTH'(k_q);
  assign last    = (k_q == cnt_q - CNT_WIDTH'(1));
  assign act     = (state_q == WR) || (state_q == RD);

  // Request fields are pure decodes of registered state, so they stay
  // stable for as long as the target withholds ack/err.
  assign wb.i_cyc   = act;
  assign wb.i_stb   = act;
  assign wb.i_we    = (state_q == WR);
  assign wb.i_adr   = act ? cur_adr : '0;
  assign wb.i_dat_w = (state_q == WR) ? cur_dat : '0;
  assign wb.i_sel   = act ? 4'hF : 4'h0;
  assign wb.i_tgd_w = 1'b0;
  assign wb.i_tga   = 1'b0;
  assign wb.i_tgc   = 1'b0;

  assign busy      = (state_q == WR) || (state_q == WGAP) ||
                     (state_q == RD) || (state_q == RGAP);
  assign done      = (state_q == FIN);
  assign pass      = pass_q;
  assign fail_adr  = fadr_q;
  assign fail_data = fdat_q;

  logic unused_ok;
  assign unused_ok = ^{wb.i_tgd_r, base_adr[1:0]};

  always_comb begin
    state_n = state_q;
    base_n  = base_q;
    cnt_n   = cnt_q;
    k_n     = k_q;
    seed_n  = seed_q;
    pass_n  = pass_q;
    fadr_n  = fadr_q;
    fdat_n  = fdat_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_n = {base_adr[ADR_WIDTH-1:2], 2'b00};
          cnt_n  = nwords;
          seed_n = seed;
          k_n    = '0;
          fadr_n = '0;
          fdat_n = '0;
          if (nwords == '0) begin
            pass_n  = 1'b1;
            state_n = FIN;
          end else begin
            pass_n  = 1'b0;
            state_n = WR;
          end
        end
      end
      WR: begin
        if (wb.i_err) begin
          fadr_n  = cur_adr;
          fdat_n  = '0;
          pass_n  = 1'b0;
          state_n = FIN;
        end else if (wb.i_ack) begin
          state_n = WGAP;
        end
      end
      WGAP: begin
        if (last) begin
          k_n     = '0;
          state_n = RD;
        end else begin
          k_n     = k_q + CNT_WIDTH'(1);
          state_n = WR;
        end
      end
      RD: begin
        if (wb.i_err) begin
          fadr_n  = cur_adr;
          fdat_n  = '0;
          pass_n  = 1'b0;
          state_n = FIN;
        end else if (wb.i_ack) begin
          if (wb.i_dat_r != cur_dat) begin
            fadr_n  = cur_adr;
            fdat_n  = wb.i_dat_r;
            pass_n  = 1'b0;
            state_n = FIN;
          end else begin
            state_n = RGAP;
          end
        end
      end
      RGAP: begin
        if (last) begin
          pass_n  = 1'b1;
          state_n = FIN;
        end else begin
          k_n     = k_q + CNT_WIDTH'(1);
          state_n = RD;
        end
      end
      FIN: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      seed_q  <= '0;
      pass_q  <= 1'b0;
      fadr_q  <= '0;
      fdat_q  <= '0;
    end else begin
      state_q <= state_n;
      base_q  <= base_n;
      cnt_q   <= cnt_n;
      k_q     <= k_n;
      seed_q  <= seed_n;
      pass_q  <= pass_n;
      fadr_q  <= fadr_n;
      fdat_q  <= fdat_n;
    end
  end

endmodule
